// File: rtl/local_memory_reader.sv
// local_memory_reader
//   Read-side initiator for one port of the dual-port local memory. A command
//   (base_addr, length) is turned into a 32-bit valid/ready stream. The memory
//   returns data one cycle after mem_rden; a 2-entry output buffer absorbs
//   consumer backpressure and sustains one word per cycle when unstalled.
//
// Ports
//   aclk, reset          clock and synchronous active-high reset
//   start                command strobe, only honoured in IDLE
//   base_addr, length    command fields, sampled with start
//   busy, done           command in progress / one-cycle completion pulse
//   mem_rden, mem_address, mem_data_in   memory read port
//   out_data, out_valid, out_ready, out_last   output stream
//
// Build option
//   LOCAL_MEMORY_READER_LAST_EN: when defined, out_last flags the final word
//   of each command; otherwise out_last is tied to 0.

module local_memory_reader #(
   parameter int SIZE_ADDR = 8,
   parameter int SIZE_LEN  = 9
) (
   input  logic                 aclk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [SIZE_ADDR-1:0] base_addr,
   input  logic [SIZE_LEN-1:0]  length,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_rden,
   output logic [SIZE_ADDR-1:0] mem_address,
   input  logic [31:0]          mem_data_in,
   output logic [31:0]          out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t               state_reg, state_next;
   logic [SIZE_LEN-1:0]  issue_cnt_reg;
   logic [SIZE_ADDR-1:0] addr_reg;
   logic                 inflight_reg;
   logic [1:0]           count_reg;
   logic [31:0]          head_reg, tail_reg;
   logic                 done_reg;
   logic                 done_next;
   logic                 rden;
   logic                 pop;
   logic                 push;
   logic                 accept_cmd;
   logic [2:0]           occupancy;
   logic                 issue_ok;
   logic                 drain_empty;

   assign pop        = (count_reg != 2'd0) && out_ready;
   // Data only arrives in the cycle after a read; otherwise the port is stale.
   assign push       = inflight_reg;
   assign accept_cmd = (state_reg == IDLE) && start && (length != '0);

   // Words already owned (buffered or returning) minus the word leaving now;
   // a new read is only safe if that leaves room for it.
   assign occupancy   = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   assign issue_ok    = occupancy < 3'd2;
   assign drain_empty = (count_reg == 2'd0) || ((count_reg == 2'd1) && pop);

   always_ff @(posedge aclk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      rden       = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (length != '0) state_next = READ;
               else              done_next  = 1'b1;
            end
         end
         READ: begin
            if ((issue_cnt_reg != '0) && issue_ok) begin
               rden = 1'b1;
               if (issue_cnt_reg == SIZE_LEN'(1)) state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Finish on the edge that retires the last word so done lands
            // in the cycle right after the final handshake.
            if (!inflight_reg && drain_empty) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         issue_cnt_reg <= '0;
         addr_reg      <= '0;
         inflight_reg  <= 1'b0;
         count_reg     <= 2'd0;
         head_reg      <= '0;
         tail_reg      <= '0;
         done_reg      <= 1'b0;
      end else begin
         done_reg     <= done_next;
         inflight_reg <= rden;

         if (accept_cmd) begin
            addr_reg      <= base_addr;
            issue_cnt_reg <= length;
         end else if (rden) begin
            addr_reg      <= addr_reg + SIZE_ADDR'(1);
            issue_cnt_reg <= issue_cnt_reg - SIZE_LEN'(1);
         end

         case ({push, pop})
            2'b10: begin
               if (count_reg == 2'd0) head_reg <= mem_data_in;
               else                   tail_reg <= mem_data_in;
               count_reg <= count_reg + 2'd1;
            end
            2'b01: begin
               if (count_reg == 2'd2) head_reg <= tail_reg;
               count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
               if (count_reg == 2'd2) begin
                  head_reg <= tail_reg;
                  tail_reg <= mem_data_in;
               end else begin
                  head_reg <= mem_data_in;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LOCAL_MEMORY_READER_LAST_EN
   // Words still to be handed to the consumer for the current command.
   logic [SIZE_LEN-1:0] out_rem_reg;

   always_ff @(posedge aclk) begin
      if (reset)           out_rem_reg <= '0;
      else if (accept_cmd) out_rem_reg <= length;
      else if (pop)        out_rem_reg <= out_rem_reg - SIZE_LEN'(1);
   end

   assign out_last = (count_reg != 2'd0) && (out_rem_reg == SIZE_LEN'(1));
`else
   assign out_last = 1'b0;
`endif

   assign busy        = (state_reg != IDLE);
   assign done        = done_reg;
   assign mem_rden    = rden;
   assign mem_address = addr_reg;
   assign out_data    = head_reg;
   assign out_valid   = (count_reg != 2'd0);

endmodule

// File: tb/tb_local_memory_reader.sv
module tb_local_memory_reader;

   logic        aclk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [8:0]  length = '0;
   logic        busy, done, mem_rden, out_valid, out_last;
   logic [7:0]  mem_address;
   logic [31:0] mem_data_in = '0;
   logic [31:0] out_data;
   logic        out_ready = 1'b1;

   local_memory_reader dut (
      .aclk        (aclk),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .mem_rden    (mem_rden),
      .mem_address (mem_address),
      .mem_data_in (mem_data_in),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last)
   );

   always #5 aclk = ~aclk;

   // Memory model: read data appears the cycle after mem_rden, else held.
   logic [31:0] mem [256];
   always @(posedge aclk) if (mem_rden) mem_data_in <= mem[mem_address];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_cnt = 0;
   int done_rel = -1;
   int first_hs = -1;
   int mcnt = 0;
   bit rden_d = 0;
   bit mon_en = 0;
   int ready_mode = 0;

   logic [31:0] exp_q[$];
   bit          last_q[$];
   logic [7:0]  addr_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   // out_ready driver: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random
   initial begin
      int pc = 0;
      forever begin
         @(posedge aclk);
         #1;
         case (ready_mode)
            1:       out_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
         pc++;
      end
   end

   // Monitor / scoreboard consumer
   always @(negedge aclk) begin
      if (mon_en) begin
         bit   pop;
         int   occ;
         logic [31:0] ed;
         bit   el;
         logic [7:0] ea;
         pop = out_valid && out_ready;
         check("valid_vs_count", {31'd0, out_valid}, {31'd0, (mcnt != 0)});
         check("buf_bound", mcnt, (mcnt > 2) ? 2 : mcnt);
         if (!out_valid) check("last_without_valid", {31'd0, out_last}, 0);
         if (pop) begin
            if (first_hs < 0) first_hs = cyc - start_cyc;
            if (exp_q.size() == 0) begin
               check("word_queue_nonempty", exp_q.size(), 1);
            end else begin
               ed = exp_q.pop_front();
               el = last_q.pop_front();
               $display("word cycle=%0d data=%08h last=%0b", cyc - start_cyc, out_data, out_last);
               check("out_data", out_data, ed);
`ifdef LOCAL_MEMORY_READER_LAST_EN
               check("out_last", {31'd0, out_last}, {31'd0, el});
`else
               check("out_last", {31'd0, out_last}, {31'd0, 1'b0 & el});
`endif
            end
         end
         if (mem_rden) begin
            occ = mcnt + int'(rden_d) - int'(pop);
            check("issue_rule", {31'd0, (occ < 2)}, 1);
            if (addr_q.size() == 0) begin
               check("addr_queue_nonempty", addr_q.size(), 1);
            end else begin
               ea = addr_q.pop_front();
               check("mem_address", {24'd0, mem_address}, {24'd0, ea});
            end
         end
         if (done) begin
            done_cnt++;
            done_rel = cyc - start_cyc;
            $display("done cycle=%0d", done_rel);
            check("busy_at_done", {31'd0, busy}, 0);
         end
         mcnt = mcnt + int'(rden_d) - int'(pop);
         rden_d = mem_rden;
      end
   end

   task automatic run_cmd(input logic [7:0] b, input int n, input int restart_at, input bit timing);
      logic [7:0] a;
      for (int i = 0; i < n; i++) begin
         a = b + 8'(i);
         exp_q.push_back(mem[a]);
         last_q.push_back(i == n - 1);
         addr_q.push_back(a);
      end
      done_cnt = 0;
      done_rel = -1;
      first_hs = -1;
      start = 1'b1;
      base_addr = b;
      length = 9'(n);
      start_cyc = cyc;
      $display("cmd base=%02h length=%0d mode=%0d", b, n, ready_mode);
      @(posedge aclk);
      #1;
      start = 1'b0;
      base_addr = 8'($urandom);
      length = 9'($urandom);
      for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
         if (restart_at > 0 && (cyc - start_cyc) == restart_at) begin
            check("busy_at_restart", {31'd0, busy}, 1);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge aclk);
         #1;
      end
      start = 1'b0;
      repeat (5) @(posedge aclk);
      #1;
      check("done_count", done_cnt, 1);
      check("words_left", exp_q.size(), 0);
      check("reads_left", addr_q.size(), 0);
      if (timing) begin
         if (n > 0) check("first_word_cycle", first_hs, 3);
         check("done_cycle", done_rel, (n == 0) ? 1 : n + 3);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'(i) + 32'h100;

      // Reset values
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_mem_rden", {31'd0, mem_rden}, 0);
      check("rst_mem_address", {24'd0, mem_address}, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_last", {31'd0, out_last}, 0);
      @(posedge aclk);
      #1;
      reset = 1'b0;
      mon_en = 1;
      repeat (2) @(posedge aclk);
      #1;

      ready_mode = 0;
      run_cmd(8'h10, 4, 0, 1);
      run_cmd(8'hFE, 4, 0, 1);
      ready_mode = 1;
      run_cmd(8'h80, 16, 0, 0);
      ready_mode = 0;
      run_cmd(8'h00, 0, 0, 1);
      run_cmd(8'h20, 8, 3, 1);
      ready_mode = 2;
      run_cmd(8'hF0, 20, 0, 0);
      run_cmd(8'h05, 256, 0, 0);
      ready_mode = 0;

      // Reset in cycle 4 of a length-8 command
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(mem[8'h60 + 8'(i)]);
         last_q.push_back(i == 7);
         addr_q.push_back(8'h60 + 8'(i));
      end
      done_cnt = 0;
      start = 1'b1;
      base_addr = 8'h60;
      length = 9'd8;
      start_cyc = cyc;
      $display("cmd base=60 length=8 with reset in cycle 4");
      @(posedge aclk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      reset = 1'b1;
      mon_en = 0;
      @(posedge aclk);
      #1;
      reset = 1'b0;
      @(negedge aclk);
      check("mid_rst_busy", {31'd0, busy}, 0);
      check("mid_rst_done", {31'd0, done}, 0);
      check("mid_rst_mem_rden", {31'd0, mem_rden}, 0);
      check("mid_rst_mem_address", {24'd0, mem_address}, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_valid", {31'd0, out_valid}, 0);
      check("mid_rst_out_last", {31'd0, out_last}, 0);
      exp_q.delete();
      last_q.delete();
      addr_q.delete();
      mcnt = 0;
      rden_d = 0;
      done_cnt = 0;
      mon_en = 1;
      repeat (20) @(posedge aclk);
      #1;
      check("post_rst_done_count", done_cnt, 0);

      run_cmd(8'h33, 5, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/local_memory_reader.md
# local_memory_reader

Read-side initiator for the dual-port local memory of the coprocessor's memory subsystem. It drives one memory port (read enable, address; 32-bit data returns one cycle after the read enable) and turns a command (base address, word count) into a 32-bit valid/ready output stream. A 2-entry output buffer absorbs backpressure and sustains one word per cycle when the consumer never stalls.

## Interface
- SIZE_ADDR, 8, memory address width; the address space is 2^SIZE_ADDR words.
- SIZE_LEN, 9, width of the length field; it allows counts up to 2^SIZE_ADDR.

Ports. One clock; reset is synchronous and active-high.
- aclk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  SIZE_ADDR  first word address; sampled with start.
- length  in  SIZE_LEN  number of words; sampled with start.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- mem_rden  out  1  read enable to the memory port.
- mem_address  out  SIZE_ADDR  read address to the memory port.
- mem_data_in  in  32  memory read data, valid the cycle after mem_rden.
- out_data  out  32  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final word (see Configuration).

## Operation
- States:
  - IDLE. start=1 with length≠0 latches address and count, then goes to READ. start=1 with length=0 pulses done for the next cycle and stays in IDLE. No memory access for length=0.
  - READ. Issues reads until the remaining-issue count reaches 0, then goes to DRAIN.
  - DRAIN. Waits until the in-flight read has returned and the buffer is empty, then pulses done and goes to IDLE.
- Read issue rule: mem_rden=1 in a cycle iff
  - issue count > 0, and
  - (buffer count + inflight − pop) < 2, where pop = out_valid & out_ready and inflight ∈ {0,1} is the read issued in the previous cycle.
- Data capture: mem_data_in is written into the buffer only in the cycle after a mem_rden. At other times it is ignored, because the memory holds its last value.
- mem_address increments by 1 after each issued read and wraps modulo 2^SIZE_ADDR; base 0xFF, length 3 reads 0xFF, 0x00, 0x01.
- Buffer: 2-entry FIFO. out_data and out_valid come from the head register. A simultaneous push and pop is legal at any count.
- Ordering: words are output in address order; no word is dropped or duplicated under any out_ready pattern.
- start while busy=1 is ignored, with no effect on the current command.
- busy=1 in READ and DRAIN. busy drops in the same cycle done pulses.
- Reset, including mid-command:
  - state returns to IDLE and the buffer is flushed;
  - any in-flight return is discarded;
  - counters are cleared;
  - no done pulse is generated.

## Timing
- Reset values: busy=0, done=0, mem_rden=0, mem_address=0, out_data=0, out_valid=0, out_last=0.
- Command latency, with start sampled at edge 0:
  - busy=1 and the first mem_rden=1 (address=base) in cycle 1;
  - data returns in cycle 2;
  - first out_valid=1 in cycle 3.
- Throughput: with out_ready held at 1, one word per cycle. N words finish their handshakes in cycles 3..N+2.
- done pulses in the cycle after the last word's handshake, i.e. cycle N+3 for an unstalled command.
- Stall: out_ready=0 stops issue within one cycle. The buffer holds at most 2 words. mem_rden never causes an overflow.

## Configuration
- LOCAL_MEMORY_READER_LAST_EN
  - Defined: out_last=1 together with out_valid on the final word of each command, 0 otherwise. A per-command output counter drives it.
  - Undefined: out_last is tied to 0 and the output counter is not built; done and busy are unchanged.

## Test plan
- Memory preloaded with mem[a]=a+0x100; base=0x10, length=4, out_ready=1 → out_data 0x110, 0x111, 0x112, 0x113 in cycles 3–6; done pulses in cycle 7; out_last=1 on 0x113 when the macro is defined.
- base=0xFE, length=4 → mem_address sequence 0xFE, 0xFF, 0x00, 0x01; data in the same order.
- length=16, out_ready toggling 1,0,0,1 repeating → all 16 words in order with no duplicates; buffer count never exceeds 2; no mem_rden issued while buffer count + inflight = 2 without a pop.
- length=0 → done pulses in cycle 1; busy, mem_rden and out_valid stay 0.
- start pulsed again during a length-8 command → ignored; exactly 8 words and one done pulse.
- reset asserted in cycle 4 of a length-8 command → all outputs at reset values in the next cycle; no further words and no done pulse; a new command then runs correctly.
